// File: rtl/layer2_pkg.sv
// Shared definitions for the layer-2 classifier: FSM encodings, SDRAM map and kernel sizes.
package layer2_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_LDW        = 4'd1,
        ST_LDW_DONE   = 4'd2,
        ST_INITSAMP   = 4'd3,
        ST_BIAS       = 4'd4,
        ST_CALC       = 4'd5,
        ST_CMP        = 4'd6,
        ST_WRITE      = 4'd7,
        ST_SAMPLEDONE = 4'd8,
        ST_DONE       = 4'd9
    } state_t;

    localparam logic [31:0] WEIGHT_ADDR = 32'h10000;
    localparam logic [31:0] INPUT_ADDR  = 32'hE000;
    localparam logic [31:0] OUT_ADDR    = 32'h12000;

    localparam int KERNEL2_BYTES     = 2010;
    localparam int WORDS_PER_SAMPLE2 = 13;

    localparam int ACC_W  = 16;
    localparam int NODE_W = 4;

    function automatic logic signed [ACC_W-1:0] sext8(input logic [7:0] b);
        return $signed({{(ACC_W-8){b[7]}}, b});
    endfunction

endpackage

// File: rtl/layer2_argmax.sv
// Running arg-max over node scores; strict signed compare so ties keep the lower node.
module layer2_argmax
    import layer2_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    en,
    input  logic [NODE_W-1:0]       node,
    input  logic signed [ACC_W-1:0] acc,
    output logic [NODE_W-1:0]       cls
);

    logic signed [ACC_W-1:0] best_q, best_d;
    logic [NODE_W-1:0]       cls_q, cls_d;

    always_comb begin
        best_d = best_q;
        cls_d  = cls_q;
        if (clear) begin
            best_d = '0;
            cls_d  = '0;
        end else if (en && (node == '0 || acc > best_q)) begin
            best_d = acc;
            cls_d  = node;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            best_q <= '0;
            cls_q  <= '0;
        end else begin
            best_q <= best_d;
            cls_q  <= cls_d;
        end
    end

    assign cls = cls_q;

endmodule

// File: rtl/layer2.sv
// Layer-2 classifier: loads the kernel into external BRAM, then per sample scores every
// node over the binary inputs and writes the arg-max class back to SDRAM.
module layer2 #(
    parameter int          NUM_NODES   = 10,
    parameter int          NUM_INPUTS  = 200,
    parameter int          NUM_SAMPLES = 100,
    parameter logic [31:0] WEIGHT_ADDR = layer2_pkg::WEIGHT_ADDR,
    parameter logic [31:0] INPUT_ADDR  = layer2_pkg::INPUT_ADDR,
    parameter logic [31:0] OUT_ADDR    = layer2_pkg::OUT_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        waitrequest,
    input  logic        readdatavalid,
    input  logic [15:0] readdata,
    output logic        read_n,
    output logic        write_n,
    output logic        chipselect,
    output logic [31:0] address,
    output logic [1:0]  byteenable,
    output logic [15:0] writedata,
    input  logic        ready,
    output logic [6:0]  done,
    output logic [3:0]  state,
    output logic [10:0] s1_adr,
    output logic [10:0] s2_adr,
    output logic [7:0]  s1_d,
    output logic [7:0]  s2_d,
    output logic        s1_w,
    output logic        s2_w,
    input  logic [7:0]  s1_q
);
    import layer2_pkg::*;

    localparam int STRIDE = NUM_INPUTS + 1;
    localparam int WORDS  = (NUM_INPUTS + 15) / 16;
    localparam int IN_W   = WORDS * 16;
    localparam int KWORDS = (NUM_NODES * STRIDE + 1) / 2;

    state_t                  state_q, state_d;
    logic [10:0]             issue_q, issue_d;
    logic [10:0]             recv_q, recv_d;
    logic [NODE_W-1:0]       node_q, node_d;
    logic [7:0]              step_q, step_d;
    logic [6:0]              done_q, done_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [IN_W-1:0]         inp_q, inp_d;
    logic                    wr_pend_q, wr_pend_d;
    logic [10:0]             wr_adr_q, wr_adr_d;
    logic [7:0]              wr_lo_q, wr_lo_d;
    logic [7:0]              wr_hi_q, wr_hi_d;

    logic signed [ACC_W-1:0] weight_ext;
    logic signed [ACC_W-1:0] acc_final;
    logic [7:0]              prev_step;
    logic [10:0]             node_base;
    logic                    issuing;
    logic [NODE_W-1:0]       cls;

    assign weight_ext = sext8(s1_q);
    assign prev_step  = step_q - 8'd1;
    assign node_base  = 11'(node_q) * 11'(STRIDE);
    // The last weight lands in CMP, so the final score is folded in combinationally there.
    assign acc_final  = acc_q + (inp_q[NUM_INPUTS-1] ? weight_ext : '0);
    assign issuing    = (state_q == ST_LDW      && issue_q < 11'(KWORDS)) ||
                        (state_q == ST_INITSAMP && issue_q < 11'(WORDS));

    always_comb begin
        state_d   = state_q;
        issue_d   = issue_q;
        recv_d    = recv_q;
        node_d    = node_q;
        step_d    = step_q;
        done_d    = done_q;
        acc_d     = acc_q;
        inp_d     = inp_q;
        wr_pend_d = 1'b0;
        wr_adr_d  = wr_adr_q;
        wr_lo_d   = wr_lo_q;
        wr_hi_d   = wr_hi_q;
        case (state_q)
            ST_IDLE: begin
                issue_d = '0;
                recv_d  = '0;
                node_d  = '0;
                step_d  = '0;
                done_d  = '0;
                acc_d   = '0;
                if (ready) state_d = ST_LDW;
            end
            ST_LDW: begin
                if (issuing && !waitrequest) issue_d = issue_q + 11'd1;
                if (readdatavalid) begin
                    wr_pend_d = 1'b1;
                    wr_adr_d  = {recv_q[9:0], 1'b0};
                    wr_lo_d   = readdata[7:0];
                    wr_hi_d   = readdata[15:8];
                    recv_d    = recv_q + 11'd1;
                    if (recv_q == 11'(KWORDS - 1)) state_d = ST_LDW_DONE;
                end
            end
            ST_LDW_DONE: begin
                issue_d = '0;
                recv_d  = '0;
                state_d = ST_INITSAMP;
            end
            ST_INITSAMP: begin
                if (issuing && !waitrequest) issue_d = issue_q + 11'd1;
                if (readdatavalid) begin
                    inp_d  = {readdata, inp_q[IN_W-1:16]};
                    recv_d = recv_q + 11'd1;
                    if (recv_q == 11'(WORDS - 1)) begin
                        node_d  = '0;
                        state_d = ST_BIAS;
                    end
                end
            end
            ST_BIAS: begin
                step_d  = '0;
                state_d = ST_CALC;
            end
            ST_CALC: begin
                step_d = step_q + 8'd1;
                // s1_q lags the issued address by one step: bias first, then weight i-1.
                if (step_q == 8'd0) acc_d = weight_ext;
                else if (inp_q[prev_step]) acc_d = acc_q + weight_ext;
                if (step_q == 8'(NUM_INPUTS - 1)) state_d = ST_CMP;
            end
            ST_CMP: begin
                acc_d = acc_final;
                if (node_q == NODE_W'(NUM_NODES - 1)) begin
                    state_d = ST_WRITE;
                end else begin
                    node_d  = node_q + 1'b1;
                    state_d = ST_BIAS;
                end
            end
            ST_WRITE: begin
                if (!waitrequest) state_d = ST_SAMPLEDONE;
            end
            ST_SAMPLEDONE: begin
                done_d  = done_q + 7'd1;
                issue_d = '0;
                recv_d  = '0;
                if (done_q + 7'd1 == 7'(NUM_SAMPLES)) state_d = ST_DONE;
                else state_d = ST_INITSAMP;
            end
            ST_DONE: begin
                if (!ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            issue_q   <= '0;
            recv_q    <= '0;
            node_q    <= '0;
            step_q    <= '0;
            done_q    <= '0;
            acc_q     <= '0;
            inp_q     <= '0;
            wr_pend_q <= 1'b0;
            wr_adr_q  <= '0;
            wr_lo_q   <= '0;
            wr_hi_q   <= '0;
        end else begin
            state_q   <= state_d;
            issue_q   <= issue_d;
            recv_q    <= recv_d;
            node_q    <= node_d;
            step_q    <= step_d;
            done_q    <= done_d;
            acc_q     <= acc_d;
            inp_q     <= inp_d;
            wr_pend_q <= wr_pend_d;
            wr_adr_q  <= wr_adr_d;
            wr_lo_q   <= wr_lo_d;
            wr_hi_q   <= wr_hi_d;
        end
    end

    layer2_argmax u_argmax (
        .clk   (clk),
        .reset (reset),
        .clear (state_q == ST_BIAS && node_q == '0),
        .en    (state_q == ST_CMP),
        .node  (node_q),
        .acc   (acc_final),
        .cls   (cls)
    );

    always_comb begin
        address = '0;
        if (issuing && state_q == ST_LDW)
            address = WEIGHT_ADDR + 32'(issue_q);
        else if (issuing)
            address = INPUT_ADDR + 32'(WORDS) * 32'(done_q) + 32'(issue_q);
        else if (state_q == ST_WRITE)
            address = OUT_ADDR + 32'(done_q);
    end

    always_comb begin
        s1_adr = '0;
        if (wr_pend_q)
            s1_adr = wr_adr_q;
        else if (state_q == ST_BIAS)
            s1_adr = node_base;
        else if (state_q == ST_CALC)
            s1_adr = node_base + 11'd1 + 11'(step_q);
    end

    assign read_n     = !issuing;
    assign write_n    = (state_q != ST_WRITE);
    assign writedata  = (state_q == ST_WRITE) ? {12'b0, cls} : 16'h0000;
    assign chipselect = 1'b1;
    assign byteenable = 2'b11;
    assign done       = done_q;
    assign state      = state_q;
    assign s2_adr     = wr_pend_q ? {wr_adr_q[10:1], 1'b1} : 11'd0;
    assign s1_d       = wr_lo_q;
    assign s2_d       = wr_hi_q;
    assign s1_w       = wr_pend_q;
    assign s2_w       = wr_pend_q;

endmodule

// File: tb/tb_layer2.sv
// Bench for layer2: SDRAM + BRAM models, a table of directed kernels, random runs against a
// loop-based golden classifier, and asynchronous resets during LDW and CALC.
module tb_layer2;

    localparam int NS     = 3;
    localparam int NK     = 2010;
    localparam int NKW    = 1005;
    localparam int WPS    = 13;
    localparam int STRIDE = 201;
    localparam logic [31:0] WADDR = 32'h10000;
    localparam logic [31:0] IADDR = 32'hE000;
    localparam logic [31:0] OADDR = 32'h12000;

    logic        clk = 1'b0;
    logic        reset;
    logic        waitrequest;
    logic        readdatavalid;
    logic [15:0] readdata;
    logic        read_n;
    logic        write_n;
    logic        chipselect;
    logic [31:0] address;
    logic [1:0]  byteenable;
    logic [15:0] writedata;
    logic        ready;
    logic [6:0]  dut_done;
    logic [3:0]  dut_state;
    logic [10:0] s1_adr;
    logic [10:0] s2_adr;
    logic [7:0]  s1_d;
    logic [7:0]  s2_d;
    logic        s1_w;
    logic        s2_w;
    logic [7:0]  s1_q;

    always #5 clk = ~clk;

    layer2 #(.NUM_SAMPLES(NS)) dut (
        .clk(clk), .reset(reset), .waitrequest(waitrequest), .readdatavalid(readdatavalid),
        .readdata(readdata), .read_n(read_n), .write_n(write_n), .chipselect(chipselect),
        .address(address), .byteenable(byteenable), .writedata(writedata), .ready(ready),
        .done(dut_done), .state(dut_state), .s1_adr(s1_adr), .s2_adr(s2_adr),
        .s1_d(s1_d), .s2_d(s2_d), .s1_w(s1_w), .s2_w(s2_w), .s1_q(s1_q)
    );

    logic [7:0]  kb     [NK];
    logic [15:0] in_w   [NS*WPS];
    logic [7:0]  bram   [2048];
    logic [15:0] out_mem[NS];
    logic [15:0] exp_word[NS];
    int          kreads;
    int          wcount;
    int          n_total = 0;
    int          n_pass  = 0;

    logic [31:0] q_addr[$];
    int          q_due[$];
    int          cyc = 0;

    typedef struct {
        int          kmode;
        int          imode;
        bit          drop;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [15:0] mem_read(input logic [31:0] a);
        int k;
        if (a >= WADDR && a < WADDR + NKW) begin
            k = int'(a - WADDR);
            return {kb[2*k+1], kb[2*k]};
        end
        if (a >= IADDR && a < IADDR + NS*WPS) return in_w[int'(a - IADDR)];
        return 16'h0000;
    endfunction

    // SDRAM (waitrequest every third cycle, fixed read latency) and BRAM (read-first) models.
    initial begin
        logic        s_rd, s_wr, s_w1, s_w2;
        logic [31:0] s_addr;
        logic [15:0] s_wd;
        logic [10:0] s_a1, s_a2;
        logic [7:0]  s_d1, s_d2, rd;
        waitrequest = 1'b0; readdatavalid = 1'b0; readdata = 16'h0; s1_q = 8'h0;
        forever begin
            @(negedge clk);
            s_rd = !read_n && !waitrequest;  s_wr = !write_n && !waitrequest;
            s_addr = address; s_wd = writedata;
            s_a1 = s1_adr; s_a2 = s2_adr; s_d1 = s1_d; s_d2 = s2_d; s_w1 = s1_w; s_w2 = s2_w;
            @(posedge clk);
            #1;
            rd = bram[s_a1];
            if (s_w1) bram[s_a1] = s_d1;
            if (s_w2) bram[s_a2] = s_d2;
            if (s_rd) begin
                q_addr.push_back(s_addr);
                q_due.push_back(cyc + 2);
                if (s_addr >= WADDR && s_addr < WADDR + NKW) kreads++;
            end
            if (s_wr) begin
                if (s_addr >= OADDR && s_addr < OADDR + NS) out_mem[int'(s_addr - OADDR)] = s_wd;
                wcount++;
            end
            s1_q = rd;
            cyc++;
            waitrequest = (cyc % 3 == 2);
            if (q_due.size() > 0 && q_due[0] <= cyc) begin
                readdatavalid = 1'b1;
                readdata = mem_read(q_addr.pop_front());
                void'(q_due.pop_front());
            end else begin
                readdatavalid = 1'b0;
                readdata = 16'($urandom);
            end
        end
    end

    task automatic build_kernel(input int mode);
        int n, i;
        for (int j = 0; j < NK; j++) begin
            n = j / STRIDE;
            i = j % STRIDE - 1;
            case (mode)
                0: kb[j] = (i < 0) ? 8'd0 : ((n == 3) ? 8'd1 : 8'hFF);
                1: begin
                    if (i >= 0) kb[j] = 8'd0;
                    else if (n == 0) kb[j] = 8'hFB;
                    else if (n == 1 || n == 2) kb[j] = 8'd7;
                    else kb[j] = 8'h80;
                end
                2: begin
                    if (i < 0) kb[j] = (n == 2) ? 8'd50 : ((n == 9) ? 8'd10 : 8'd0);
                    else kb[j] = (n == 9 && i >= 192) ? 8'd100 : 8'd0;
                end
                default: kb[j] = 8'($urandom_range(0, 255));
            endcase
        end
    endtask

    task automatic build_inputs(input int mode);
        for (int j = 0; j < NS*WPS; j++) begin
            case (mode)
                0: in_w[j] = 16'hFFFF;
                1: in_w[j] = 16'h0000;
                2: in_w[j] = (j % WPS == 12) ? 16'hFF00 : 16'h0000;
                default: in_w[j] = 16'($urandom);
            endcase
        end
    endtask

    function automatic logic [15:0] golden(input int s);
        int best, cls, acc, idx;
        best = 0; cls = 0;
        for (int n = 0; n < 10; n++) begin
            acc = int'($signed(kb[n*STRIDE]));
            for (int i = 0; i < 200; i++) begin
                idx = s*WPS + i/16;
                if (in_w[idx][i%16]) acc += int'($signed(kb[n*STRIDE + 1 + i]));
            end
            acc = int'($signed(16'(acc)));
            if (n == 0 || acc > best) begin
                best = acc;
                cls = n;
            end
        end
        return 16'(cls);
    endfunction

    task automatic do_run(input bit drop_mid, input string tag);
        bit reached;
        int mism;
        for (int s = 0; s < NS; s++) out_mem[s] = 16'hDEAD;
        kreads = 0; wcount = 0; reached = 0;
        @(negedge clk);
        ready = 1'b1;
        for (int n = 0; n < 20000 && !reached; n++) begin
            @(negedge clk);
            if (dut_state == 4'd9) reached = 1;
            if (drop_mid && dut_state == 4'd3) ready = 1'b0;
        end
        check($sformatf("%s_reached_done", tag), 32'(reached), 32'd1);
        check($sformatf("%s_done_count", tag), 32'(dut_done), 32'(NS));
        ready = 1'b0;
        @(negedge clk);
        check($sformatf("%s_back_to_idle", tag), 32'(dut_state), 32'd0);
        check($sformatf("%s_kernel_reads", tag), 32'(kreads), 32'(NKW));
        check($sformatf("%s_writes", tag), 32'(wcount), 32'(NS));
        mism = 0;
        for (int j = 0; j < NK; j++) if (bram[j] !== kb[j]) mism++;
        check($sformatf("%s_bram_mismatches", tag), 32'(mism), 32'd0);
        for (int s = 0; s < NS; s++)
            check($sformatf("%s_out[%0d]", tag, s), 32'(out_mem[s]), 32'(exp_word[s]));
        $display("run %s: class words %h %h %h", tag, out_mem[0], out_mem[1], out_mem[2]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check($sformatf("%s_state", tag), 32'(dut_state), 32'd0);
        check($sformatf("%s_done", tag), 32'(dut_done), 32'd0);
        check($sformatf("%s_read_n", tag), 32'(read_n), 32'd1);
        check($sformatf("%s_write_n", tag), 32'(write_n), 32'd1);
        check($sformatf("%s_bram_we", tag), 32'({s1_w, s2_w}), 32'd0);
        check($sformatf("%s_address", tag), address, 32'd0);
        check($sformatf("%s_writedata", tag), 32'(writedata), 32'd0);
    endtask

    initial begin
        bit found;
        vecs[0] = '{kmode: 0, imode: 0, drop: 1'b0, exp: 16'h0003};
        vecs[1] = '{kmode: 1, imode: 3, drop: 1'b1, exp: 16'h0001};
        vecs[2] = '{kmode: 2, imode: 2, drop: 1'b0, exp: 16'h0002};
        for (int j = 0; j < 2048; j++) bram[j] = 8'h00;
        reset = 1'b1; ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_without_ready", 32'(dut_state), 32'd0);

        for (int v = 0; v < 3; v++) begin
            build_kernel(vecs[v].kmode);
            build_inputs(vecs[v].imode);
            for (int s = 0; s < NS; s++) exp_word[s] = vecs[v].exp;
            do_run(vecs[v].drop, $sformatf("vec%0d", v));
        end

        // Reset while kernel reads are in flight; stale data must not disturb the reload.
        build_kernel(3);
        build_inputs(3);
        @(negedge clk);
        ready = 1'b1;
        repeat (60) @(negedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        #1 check_reset_outputs("rst_ldw");
        ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        for (int s = 0; s < NS; s++) exp_word[s] = golden(s);
        do_run(1'b0, "rand_a");

        // Reset in the middle of CALC for sample 1, then a full rerun on new data.
        build_kernel(3);
        build_inputs(3);
        @(negedge clk);
        ready = 1'b1;
        found = 0;
        for (int n = 0; n < 20000 && !found; n++) begin
            @(negedge clk);
            if (dut_state == 4'd5 && dut_done == 7'd1) found = 1;
        end
        check("reach_calc_sample1", 32'(found), 32'd1);
        repeat (37) @(posedge clk);
        #3 reset = 1'b1;
        #1 check_reset_outputs("rst_calc");
        ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        for (int s = 0; s < NS; s++) exp_word[s] = golden(s);
        do_run(1'b0, "rand_b");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/layer2.md
LAYER2 -- requirements
Module: layer2

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NUM_NODES, 10, output nodes (classes).
- NUM_INPUTS, 200, binary inputs per sample, as produced by layer 1.
- NUM_SAMPLES, 100, samples per run.
- WEIGHT_ADDR, 32'h10000, SDRAM word address of the layer-2 kernel.
- INPUT_ADDR, 32'hE000, SDRAM word address of the layer-1 results.
- OUT_ADDR, 32'h12000, SDRAM word address of the class results.

REQ-002 One clock; reset is asynchronous and active-high.

REQ-003 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, clock.
- reset, in, 1, asynchronous active-high reset.
- waitrequest, in, 1, SDRAM stall.
- readdatavalid, in, 1, read data valid.
- readdata, in, 16, SDRAM read data.
- read_n, out, 1, active-low read.
- write_n, out, 1, active-low write.
- chipselect, out, 1, constant 1.
- address, out, 32, SDRAM word address.
- byteenable, out, 2, constant 2'b11.
- writedata, out, 16, result word.
- ready, in, 1, start and hold.
- done, out, 7, samples completed.
- state, out, 4, FSM state for debug.
- s1_adr, out, 11, BRAM port A address.
- s2_adr, out, 11, BRAM port B address.
- s1_d, out, 8, port A write data.
- s2_d, out, 8, port B write data.
- s1_w, out, 1, port A write enable.
- s2_w, out, 1, port B write enable.
- s1_q, in, 8, port A read data; 1-cycle registered latency.

Function
REQ-004 Kernel layout: 2010 signed 8-bit bytes. Node n bias at byte n*201; weight for input i at byte n*201+1+i. The kernel is stored in 1005 SDRAM words, low byte first.

REQ-005 Input layout: 13 words per sample at INPUT_ADDR+13*s. Input i = word i/16, bit i%16. Word 12 carries valid bits only in [7:0]; bits [15:8] are ignored.

REQ-006 FSM states: IDLE=0, LDW=1, LDW_DONE=2, INITSAMP=3, BIAS=4, CALC=5, CMP=6, WRITE=7, SAMPLEDONE=8, DONE=9. Any other encoding returns to IDLE on the next clock.

REQ-007 IDLE: all counters cleared; go to LDW when ready=1.

REQ-008 LDW:
- read_n=0 while words issued <1005.
- The read address and issue count advance only on a cycle with read_n=0 and waitrequest=0.
- Each readdatavalid writes readdata[7:0] to byte 2k via port A and readdata[15:8] to byte 2k+1 via port B, where k is the received-word count.
- Go to LDW_DONE when 1005 words have been received.

REQ-009 LDW_DONE lasts one cycle, then INITSAMP.

REQ-010 INITSAMP:
- Issue 13 reads using the LDW handshake rules.
- Received words shift into a 208-bit input register, first word in the LSBs.
- After the 13th word go to BIAS with node=0.

REQ-011 BIAS: port A address = node*201; the sign-extended s1_q initialises a 16-bit signed accumulator one cycle later.

REQ-012 CALC:
- Step i=0..199, one per cycle, no stalls.
- Address node*201+1+i is issued each cycle.
- The returned weight is sign-extended and added iff input bit i=1.
- The accumulator stays 16-bit with no saturation; the worst case is 25728.

REQ-013 CMP, one cycle:
- If node=0 or acc > best (strictly signed), best ← acc and cls ← node. Ties keep the lower index.
- node<9: node+1, go to BIAS. Else go to WRITE.

REQ-014 WRITE:
- write_n=0, address=OUT_ADDR+s, writedata={12'b0,cls}.
- Hold until waitrequest=0, then go to SAMPLEDONE.

REQ-015 SAMPLEDONE: done increments. If done reaches 100, go to DONE; otherwise go to INITSAMP at the next sample.

REQ-016 DONE: hold until ready=0, then go to IDLE.

REQ-017 Outside LDW and INITSAMP, read_n=1. Outside WRITE, write_n=1. In IDLE, DONE and all compute states, address=0.

REQ-018 readdatavalid outside LDW and INITSAMP is ignored.

REQ-019 ready deasserting mid-run has no effect until DONE.

Reset
REQ-020 Reset asserted at any time, including mid-transaction:
- state=IDLE, done=0, read_n=1, write_n=1, s1_w=s2_w=0, address=0, writedata=0.
- All counters, the accumulator, best and cls clear.
- In-flight readdatavalid after reset is ignored.

REQ-021 Outputs are registered or decoded only from state and registers; there is no combinational path from readdata.

Structure
REQ-022 A shared package holds:
- the state encodings;
- address constants WEIGHT_ADDR, INPUT_ADDR, OUT_ADDR;
- sizes KERNEL2_BYTES=2010, WORDS_PER_SAMPLE2=13.

REQ-023 Sub-module: layer2_argmax, holding the best/cls register and compare logic, cleared at BIAS of node 0.

REQ-024 The BRAM is external, 2048x8 true dual-port; it is not instantiated in this block.

Verification
REQ-025 Kernel load: SDRAM model with waitrequest high on every third cycle. After LDW, BRAM byte j equals kernel[j] for all 2010 bytes, and exactly 1005 reads are issued.

REQ-026 Single class: all biases 0, node 3 weights all +1, others all -1; all inputs 1. Word at OUT_ADDR = 16'h0003.

REQ-027 Tie and sign: all weights 0, biases {-5,7,7,-128,...}. The result is class 1; a tie never selects 2.

REQ-028 Word-12 masking: inputs 0 except word 12 = 16'hFF00; node 9 weights for inputs 192..199 = +100. The result is the bias argmax, with bits 15:8 ignored.

REQ-029 Full run: 100 samples with random inputs against a golden model. All 100 OUT words match, done = 100, and state goes 9 then 0 after ready drops.

REQ-030 Reset mid-run: reset asserted during CALC of sample 5. Outputs take their reset values immediately; a fresh ready restarts from LDW, and results match the golden model.
